// File: rtl/mem_stage_if.sv
// EXE->MEM input bundle and MEM->WB result bundle of the memory-access stage.
// The stage itself connects through the slave modport.
interface mem_stage_if;
    logic        ex_wreg;
    logic        ex_m2reg;
    logic        ex_wmem;
    logic [31:0] ex_aluR;
    logic [31:0] ex_inB;
    logic [4:0]  ex_destR;
    logic [3:0]  EXE_ins_type;
    logic [3:0]  EXE_ins_number;

    logic        mem_wreg;
    logic        mem_m2reg;
    logic [31:0] mem_aluR;
    logic [31:0] mem_mdata;
    logic [4:0]  mem_destR;
    logic        mem_misalign;
    logic [3:0]  MEM_ins_type;
    logic [3:0]  MEM_ins_number;

    modport master (
        output ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR,
               EXE_ins_type, EXE_ins_number,
        input  mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR,
               mem_misalign, MEM_ins_type, MEM_ins_number
    );

    modport slave (
        input  ex_wreg, ex_m2reg, ex_wmem, ex_aluR, ex_inB, ex_destR,
               EXE_ins_type, EXE_ins_number,
        output mem_wreg, mem_m2reg, mem_aluR, mem_mdata, mem_destR,
               mem_misalign, MEM_ins_type, MEM_ins_number
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: EXE/MEM pipeline register plus a word-addressed
// data RAM with asynchronous read, aligned-only stores and misalignment flag.
module mem_stage #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    logic          r_wreg;
    logic          r_m2reg;
    logic          r_wmem;
    logic [31:0]   r_aluR;
    logic [31:0]   r_inB;
    logic [4:0]    r_destR;
    logic [3:0]    r_insType;
    logic [3:0]    r_insNumber;
    logic [31:0]   r_dmem [DEPTH];

    logic [AW-1:0] w_index;
    logic          w_misalign;

    // Upper address bits are dropped, so byte addresses wrap modulo DEPTH*4.
    assign w_index    = r_aluR[AW+1:2];
    assign w_misalign = (r_wmem | r_m2reg) & (r_aluR[1:0] != 2'b00);

    // Reset wins over an in-flight store, so the cleared word stays zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wreg      <= 1'b0;
            r_m2reg     <= 1'b0;
            r_wmem      <= 1'b0;
            r_aluR      <= '0;
            r_inB       <= '0;
            r_destR     <= '0;
            r_insType   <= '0;
            r_insNumber <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dmem[i] <= '0;
            end
        end else begin
            if (r_wmem && !w_misalign) begin
                r_dmem[w_index] <= r_inB;
            end
            r_wreg      <= bus.ex_wreg;
            r_m2reg     <= bus.ex_m2reg;
            r_wmem      <= bus.ex_wmem;
            r_aluR      <= bus.ex_aluR;
            r_inB       <= bus.ex_inB;
            r_destR     <= bus.ex_destR;
            r_insType   <= bus.EXE_ins_type;
            r_insNumber <= bus.EXE_ins_number;
        end
    end

    assign bus.mem_wreg       = r_wreg & ~(r_m2reg & w_misalign);
    assign bus.mem_m2reg      = r_m2reg;
    assign bus.mem_aluR       = r_aluR;
    assign bus.mem_mdata      = r_dmem[w_index];
    assign bus.mem_destR      = r_destR;
    assign bus.mem_misalign   = w_misalign;
    assign bus.MEM_ins_type   = r_insType;
    assign bus.MEM_ins_number = r_insNumber;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; each task drives one scenario
// and compares the MEM-cycle outputs against hand-computed values.
module tb_mem_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_if bus ();

    mem_stage #(.DEPTH(64), .AW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present one instruction to EXE, clock it into MEM, then settle #1.
    task automatic applyStimulus(input logic wreg, input logic m2reg, input logic wmem,
                                 input logic [31:0] aluR, input logic [31:0] inB,
                                 input logic [4:0] destR, input logic [3:0] typ,
                                 input logic [3:0] num);
        bus.ex_wreg        = wreg;
        bus.ex_m2reg       = m2reg;
        bus.ex_wmem        = wmem;
        bus.ex_aluR        = aluR;
        bus.ex_inB         = inB;
        bus.ex_destR       = destR;
        bus.EXE_ins_type   = typ;
        bus.EXE_ins_number = num;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
                          5'($urandom), 4'($urandom), 4'($urandom));
        end
        checks++;
        if ({bus.mem_wreg, bus.mem_m2reg, bus.mem_misalign} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b required 000",
                     {bus.mem_wreg, bus.mem_m2reg, bus.mem_misalign});
        end
        checks++;
        if ({bus.mem_aluR, bus.mem_mdata, bus.mem_destR} !== 69'd0) begin
            errors++;
            $display("[TB] FAIL reset_data got aluR=%h mdata=%h destR=%0d required 0",
                     bus.mem_aluR, bus.mem_mdata, bus.mem_destR);
        end
        checks++;
        if ({bus.MEM_ins_type, bus.MEM_ins_number} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_tags got %h required 00",
                     {bus.MEM_ins_type, bus.MEM_ins_number});
        end
        rst = 1'b0;
        applyStimulus(1, 1, 0, 32'h0, 32'h0, 5'd1, 4'd0, 4'd0);
        checks++;
        if (bus.mem_mdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_load0 got %h required 00000000", bus.mem_mdata);
        end
    endtask

    task automatic test_passthrough;
        applyStimulus(1, 0, 0, 32'h55, 32'h0, 5'd9, 4'd3, 4'd7);
        checks++;
        if (bus.mem_aluR !== 32'h55) begin
            errors++;
            $display("[TB] FAIL pass_aluR got %h required 00000055", bus.mem_aluR);
        end
        checks++;
        if ({bus.mem_wreg, bus.mem_m2reg, bus.mem_misalign} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL pass_flags got %b required 100",
                     {bus.mem_wreg, bus.mem_m2reg, bus.mem_misalign});
        end
        checks++;
        if (bus.mem_destR !== 5'd9) begin
            errors++;
            $display("[TB] FAIL pass_destR got %0d required 9", bus.mem_destR);
        end
        checks++;
        if (bus.MEM_ins_type !== 4'd3 || bus.MEM_ins_number !== 4'd7) begin
            errors++;
            $display("[TB] FAIL pass_tags got type=%0d num=%0d required 3/7",
                     bus.MEM_ins_type, bus.MEM_ins_number);
        end
    endtask

    task automatic test_store_load;
        applyStimulus(0, 0, 1, 32'h10, 32'hDEADBEEF, 5'd0, 4'd1, 4'd1);
        checks++;
        if (bus.mem_wreg !== 1'b0 || bus.mem_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL st_flags got wreg=%b misalign=%b required 0/0",
                     bus.mem_wreg, bus.mem_misalign);
        end
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 5'd5, 4'd2, 4'd2);
        checks++;
        if (bus.mem_mdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL stld_mdata got %h required deadbeef", bus.mem_mdata);
        end
        checks++;
        if ({bus.mem_wreg, bus.mem_m2reg, bus.mem_misalign} !== 3'b110 || bus.mem_destR !== 5'd5) begin
            errors++;
            $display("[TB] FAIL stld_ctrl got flags=%b destR=%0d required 110/5",
                     {bus.mem_wreg, bus.mem_m2reg, bus.mem_misalign}, bus.mem_destR);
        end
    endtask

    task automatic test_wrap;
        applyStimulus(0, 0, 1, 32'h100, 32'h12345678, 5'd0, 4'd1, 4'd3);
        applyStimulus(1, 1, 0, 32'h0, 32'h0, 5'd6, 4'd2, 4'd4);
        checks++;
        if (bus.mem_mdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL wrap_load0 got %h required 12345678", bus.mem_mdata);
        end
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 5'd6, 4'd2, 4'd5);
        checks++;
        if (bus.mem_mdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL wrap_keep10 got %h required deadbeef", bus.mem_mdata);
        end
    endtask

    task automatic test_misalign;
        applyStimulus(0, 0, 1, 32'h22, 32'hFFFFFFFF, 5'd0, 4'd1, 4'd6);
        checks++;
        if (bus.mem_misalign !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mis_store_flag got %b required 1", bus.mem_misalign);
        end
        applyStimulus(1, 1, 0, 32'h20, 32'h0, 5'd7, 4'd2, 4'd7);
        checks++;
        if (bus.mem_mdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL mis_store_dropped got %h required 00000000", bus.mem_mdata);
        end
        applyStimulus(1, 1, 0, 32'h21, 32'h0, 5'd8, 4'd2, 4'd8);
        checks++;
        if (bus.mem_misalign !== 1'b1 || bus.mem_wreg !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mis_load got misalign=%b wreg=%b required 1/0",
                     bus.mem_misalign, bus.mem_wreg);
        end
        applyStimulus(1, 0, 0, 32'h23, 32'h0, 5'd8, 4'd0, 4'd9);
        checks++;
        if (bus.mem_misalign !== 1'b0 || bus.mem_wreg !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mis_alu_ignored got misalign=%b wreg=%b required 0/1",
                     bus.mem_misalign, bus.mem_wreg);
        end
    endtask

    task automatic test_back_to_back;
        applyStimulus(0, 0, 1, 32'h30, 32'h11111111, 5'd0, 4'd1, 4'd10);
        applyStimulus(0, 0, 1, 32'h1030, 32'h22222222, 5'd0, 4'd1, 4'd11);
        applyStimulus(1, 1, 0, 32'h30, 32'h0, 5'd3, 4'd2, 4'd12);
        checks++;
        if (bus.mem_mdata !== 32'h22222222) begin
            errors++;
            $display("[TB] FAIL b2b_later_wins got %h required 22222222", bus.mem_mdata);
        end
    endtask

    task automatic test_bubble;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 4'd0, 4'd0);
        checks++;
        if (bus.mem_wreg !== 1'b0 || bus.mem_misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bubble_flags got wreg=%b misalign=%b required 0/0",
                     bus.mem_wreg, bus.mem_misalign);
        end
        checks++;
        if (bus.mem_mdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL bubble_mem got %h required 12345678", bus.mem_mdata);
        end
    endtask

    task automatic test_reset_mid_store;
        applyStimulus(0, 0, 1, 32'h8, 32'hA5A5A5A5, 5'd0, 4'd1, 4'd13);
        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 5'd0, 4'd0, 4'd0);
        rst = 1'b0;
        applyStimulus(1, 1, 0, 32'h8, 32'h0, 5'd4, 4'd2, 4'd14);
        checks++;
        if (bus.mem_mdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid_store got %h required 00000000", bus.mem_mdata);
        end
        applyStimulus(1, 1, 0, 32'h10, 32'h0, 5'd4, 4'd2, 4'd15);
        checks++;
        if (bus.mem_mdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rst_clears_mem got %h required 00000000", bus.mem_mdata);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.ex_wreg = 0; bus.ex_m2reg = 0; bus.ex_wmem = 0;
        bus.ex_aluR = '0; bus.ex_inB = '0; bus.ex_destR = '0;
        bus.EXE_ins_type = '0; bus.EXE_ins_number = '0;
        test_reset();
        test_passthrough();
        test_store_load();
        test_wrap();
        test_misalign();
        test_back_to_back();
        test_bubble();
        test_reset_mid_store();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
